// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage (master) and dmem_responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, word-addressed SRAM, optional wait states.
// Define DMEM_ALIGN_CHECK_EN to reject byte-enable patterns that are not naturally aligned.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input logic              clk,
    input logic              rst_n,
    dmem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;
    logic        err_q;
    logic        err_d;
    logic        valid_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic          accept;
    logic          inRange;
    logic          beLegal;
    logic          reqOk;
    logic [AW-1:0] wordIdx;
    logic          unused_addrLsb;

    assign wordIdx        = bus.req_addr[AW+1:2];
    assign inRange        = ({2'b00, bus.req_addr[31:2]} < 32'(DEPTH_WORDS));
    assign unused_addrLsb = ^bus.req_addr[1:0];

`ifdef DMEM_ALIGN_CHECK_EN
    always_comb begin
        beLegal = 1'b0;
        case (bus.req_be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: beLegal = 1'b1;
            default:                   beLegal = 1'b0;
        endcase
    end
`else
    assign beLegal = 1'b1;
`endif

    assign reqOk         = inRange & beLegal;
    assign bus.req_ready = (state_q == IDLE) | ((state_q == RESP) & bus.rsp_ready);
    assign accept        = bus.req_valid & bus.req_ready;

    assign rdata_d = (reqOk && !bus.req_we) ? mem_q[wordIdx] : 32'h0;
    assign err_d   = ~reqOk;

    // Array has no reset so committed stores survive rst_n; writes are blocked while in reset.
    always_ff @(posedge clk) begin
        if (rst_n && accept && bus.req_we && reqOk) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req_be[i]) begin
                    mem_q[wordIdx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    // An accept in RESP (rsp_ready high) retires the old response and starts the new one together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (accept) begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (WAIT_CYCLES == 0) begin
                state_q <= RESP;
                valid_q <= 1'b1;
                cnt_q   <= 4'd0;
            end else begin
                state_q <= BUSY;
                valid_q <= 1'b0;
                cnt_q   <= 4'(WAIT_CYCLES);
            end
        end else begin
            case (state_q)
                BUSY: begin
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                        valid_q <= 1'b1;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid = valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule
